// File: rtl/sample_capture_buffer_pkg.sv
// Shared definitions for the sample capture buffer: default sizes, the
// rate-check counter width and the capture FSM state encoding.
package sample_capture_buffer_pkg;

    localparam int CAP_DATA_W          = 24;
    localparam int CAP_ADDR_W          = 12;
    localparam int CAP_SAMPLE_INTERVAL = 196;

    // Width of the strobe-interval counter; it saturates at all-ones.
    localparam int RATE_CNT_W = 10;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_CAPTURE = 2'd1;
    localparam state_t S_DONE    = 2'd2;

endpackage

// File: rtl/sample_capture_buffer_if.sv
// Bus bundle of the sample capture buffer: capture control, sample stream,
// read port and status. The master drives requests, the slave is the buffer.
interface sample_capture_buffer_if #(
    parameter int DATA_W = sample_capture_buffer_pkg::CAP_DATA_W,
    parameter int ADDR_W = sample_capture_buffer_pkg::CAP_ADDR_W
);
    logic              arm;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              rate_err;

    modport master (
        output arm, sample_valid, sample_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, done, wr_count, rate_err
    );

    modport slave (
        input  arm, sample_valid, sample_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy, done, wr_count, rate_err
    );

endinterface

// File: rtl/sample_capture_buffer_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module capture_ram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // Storage array is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last word while no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_capture_buffer.sv
// Sample capture buffer: stores a fixed-length burst of strobed samples in
// the capture RAM after an arm pulse and exposes a 1-cycle read port.
// Optional feature: define SAMPLE_RATE_CHECK_EN to build the strobe-interval
// checker that drives rate_err; without it rate_err is tied low.
import sample_capture_buffer_pkg::*;

module sample_capture_buffer #(
    parameter int DATA_W          = CAP_DATA_W,
    parameter int ADDR_W          = CAP_ADDR_W,
    parameter int NUM_SAMPLES     = 4096,
    parameter int SAMPLE_INTERVAL = CAP_SAMPLE_INTERVAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sample_capture_buffer_if.slave bus
);

    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(NUM_SAMPLES);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);

    if (NUM_SAMPLES < 1 || NUM_SAMPLES > (1 << ADDR_W)) begin : g_bad_num_samples
        $error("sample_capture_buffer: NUM_SAMPLES must lie in 1..2**ADDR_W");
    end

    if (SAMPLE_INTERVAL < 1 || SAMPLE_INTERVAL >= (1 << RATE_CNT_W)) begin : g_bad_interval
        $error("sample_capture_buffer: SAMPLE_INTERVAL must fit the interval counter");
    end

    state_t          state;
    logic [ADDR_W:0] wr_count;
    logic            wr_en;
    logic            rd_valid;

    // A strobe is only stored while capturing; an arm in the same cycle wins.
    assign wr_en = (state == S_CAPTURE) && bus.sample_valid && !bus.arm;

    // Capture FSM and write pointer; the pointer stops at NUM_SAMPLES because
    // the FSM leaves CAPTURE on the write that reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_count <= '0;
        end else if (bus.arm) begin
            state    <= S_CAPTURE;
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + COUNT_ONE;
            if (wr_count + COUNT_ONE == LAST_COUNT) begin
                state <= S_DONE;
            end
        end
    end

    // Read data accompanies a valid flag one cycle after each request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_capture_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_count[ADDR_W-1:0]),
        .wdata (bus.sample_data),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

`ifdef SAMPLE_RATE_CHECK_EN
    localparam logic [RATE_CNT_W-1:0] INTERVAL = RATE_CNT_W'(SAMPLE_INTERVAL);

    logic [RATE_CNT_W-1:0] interval_cnt;
    logic                  seen_first;
    logic                  rate_err;

    // Counts clocks since the last stored strobe; the counter reads 1 in the
    // cycle after a strobe, so at the next strobe it equals the interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_cnt <= '0;
            seen_first   <= 1'b0;
            rate_err     <= 1'b0;
        end else if (bus.arm) begin
            interval_cnt <= '0;
            seen_first   <= 1'b0;
            rate_err     <= 1'b0;
        end else if (wr_en) begin
            interval_cnt <= RATE_CNT_W'(1);
            seen_first   <= 1'b1;
            if (seen_first && interval_cnt != INTERVAL) begin
                rate_err <= 1'b1;
            end
        end else if (interval_cnt != '1) begin
            interval_cnt <= interval_cnt + RATE_CNT_W'(1);
        end
    end

    assign bus.rate_err = rate_err;
`else
    assign bus.rate_err = 1'b0;
`endif

    assign bus.busy     = (state == S_CAPTURE);
    assign bus.done     = (state == S_DONE);
    assign bus.wr_count = wr_count;
    assign bus.rd_valid = rd_valid;

endmodule
